// File: rtl/mono8_serializer_if.sv
// Handshake bundle for the Mono8 burst serializer: frame control, burst input, pixel output.
// master = serializer side, slave = the environment that feeds and drains it.
interface mono8_serializer_if #(
   parameter int IN_PIXEL_BIT_WIDTH = 8,
   parameter int PIXEL_BIT_WIDTH    = 10,
   parameter int PIXELS_PER_BURST   = 8,
   parameter int IN_ROWS            = 20,
   parameter int IN_COLS            = 16
);
   localparam int COL_W = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
   localparam int ROW_W = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;

   logic                                       ap_start;
   logic                                       ap_done;
   logic                                       ap_idle;
   logic                                       frame_err;
   logic                                       s_axis_tvalid;
   logic                                       s_axis_tready;
   logic [PIXELS_PER_BURST*IN_PIXEL_BIT_WIDTH-1:0] s_axis_tdata;
   logic                                       s_axis_tuser;
   logic                                       m_axis_tvalid;
   logic                                       m_axis_tready;
   logic [PIXEL_BIT_WIDTH-1:0]                 m_axis_tdata;
   logic [COL_W-1:0]                           cnt_col;
   logic [ROW_W-1:0]                           cnt_row;

   modport master (
      input  ap_start, s_axis_tvalid, s_axis_tdata, s_axis_tuser, m_axis_tready,
      output ap_done, ap_idle, frame_err, s_axis_tready, m_axis_tvalid, m_axis_tdata,
             cnt_col, cnt_row
   );

   modport slave (
      output ap_start, s_axis_tvalid, s_axis_tdata, s_axis_tuser, m_axis_tready,
      input  ap_done, ap_idle, frame_err, s_axis_tready, m_axis_tvalid, m_axis_tdata,
             cnt_col, cnt_row
   );
endinterface

// File: rtl/mono8_serializer.sv
// Front stage of the crop/normalize pipeline: unpacks Mono8 bursts into one zero-extended
// pixel per cycle, tagging each with its (cnt_col, cnt_row) image coordinate.
module mono8_serializer #(
   parameter int IN_PIXEL_BIT_WIDTH = 8,
   parameter int PIXEL_BIT_WIDTH    = 10,
   parameter int PIXELS_PER_BURST   = 8,
   parameter int IN_ROWS            = 20,
   parameter int IN_COLS            = 16
) (
   input  logic              clk,
   input  logic              s_axis_resetn,
   mono8_serializer_if.master bus
);
   localparam int BUF_W  = PIXELS_PER_BURST * IN_PIXEL_BIT_WIDTH;
   localparam int COL_W  = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
   localparam int ROW_W  = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
   localparam int IDX_W  = (PIXELS_PER_BURST > 1) ? $clog2(PIXELS_PER_BURST) : 1;
   localparam int BURSTS = (IN_COLS / PIXELS_PER_BURST) * IN_ROWS;
   localparam int BCNT_W = $clog2(BURSTS + 1);

   localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IN_COLS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(IN_ROWS - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PIXELS_PER_BURST - 1);
   localparam logic [BCNT_W-1:0] ALL_BURSTS = BCNT_W'(BURSTS);

   typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, DONE} state_t;

   state_t                  state;
   logic [BUF_W-1:0]        buf_data;
   logic                    buf_valid;
   logic [IDX_W-1:0]        idx;
   logic [COL_W-1:0]        col_q;
   logic [ROW_W-1:0]        row_q;
   logic [BCNT_W-1:0]       bursts_in;
   logic                    frame_err_q;
   logic                    ap_done_q;
   logic                    ap_idle_q;

   logic                    s_ready;
   logic                    s_hs;
   logic                    m_hs;
   logic                    last_lane;
   logic                    last_pixel;
   logic [IN_PIXEL_BIT_WIDTH-1:0] lane;

   assign m_hs       = buf_valid && bus.m_axis_tready;
   assign last_lane  = (idx == LAST_IDX);
   assign last_pixel = (col_q == LAST_COL) && (row_q == LAST_ROW);
   assign s_hs       = bus.s_axis_tvalid && s_ready;

   // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      s_ready = 1'b0;
      case (state)
         WAIT_SOF: s_ready = 1'b1;
         // Refill exactly as the last lane leaves, unless the whole frame is already in.
         RUN:      s_ready = (bursts_in != ALL_BURSTS) && (!buf_valid || (m_hs && last_lane));
         default:  s_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!s_axis_resetn) begin
         state       <= IDLE;
         buf_valid   <= 1'b0;
         idx         <= '0;
         col_q       <= '0;
         row_q       <= '0;
         bursts_in   <= '0;
         frame_err_q <= 1'b0;
         ap_done_q   <= 1'b0;
         ap_idle_q   <= 1'b1;
      end else begin
         ap_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.ap_start) begin
                  state       <= WAIT_SOF;
                  ap_idle_q   <= 1'b0;
                  frame_err_q <= 1'b0;
                  col_q       <= '0;
                  row_q       <= '0;
                  bursts_in   <= '0;
                  idx         <= '0;
               end
            end
            WAIT_SOF: begin
               if (s_hs && bus.s_axis_tuser) begin
                  state     <= RUN;
                  buf_valid <= 1'b1;
                  idx       <= '0;
                  bursts_in <= BCNT_W'(1);
               end
            end
            RUN: begin
               if (m_hs) begin
                  if (last_lane) begin
                     idx       <= '0;
                     buf_valid <= 1'b0;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
                  if (col_q == LAST_COL) begin
                     col_q <= '0;
                     row_q <= (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
                  if (last_pixel) begin
                     state     <= DONE;
                     ap_done_q <= 1'b1;
                  end
               end
               // A mid-frame SOF is flagged but still treated as ordinary pixel data.
               if (s_hs) begin
                  buf_valid <= 1'b1;
                  idx       <= '0;
                  bursts_in <= bursts_in + BCNT_W'(1);
                  if (bus.s_axis_tuser) frame_err_q <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               ap_idle_q <= 1'b1;
            end
         endcase
      end
   end

   // NOTE: the burst buffer is deliberately not reset; buf_valid alone qualifies its contents.
   always_ff @(posedge clk) begin
      if (s_hs) buf_data <= bus.s_axis_tdata;
   end

   assign lane = buf_data[int'(idx)*IN_PIXEL_BIT_WIDTH +: IN_PIXEL_BIT_WIDTH];

   assign bus.s_axis_tready = s_ready;
   assign bus.m_axis_tvalid = buf_valid;
   assign bus.m_axis_tdata  = buf_valid ? PIXEL_BIT_WIDTH'(lane) : '0;
   assign bus.cnt_col       = col_q;
   assign bus.cnt_row       = row_q;
   assign bus.frame_err     = frame_err_q;
   assign bus.ap_done       = ap_done_q;
   assign bus.ap_idle       = ap_idle_q;
endmodule

// File: tb/tb_mono8_serializer.sv
// Self-checking bench for mono8_serializer on a 16x4 frame: a queue-based model predicts
// every output pixel and its coordinate from the bursts the bench hands over.
module tb_mono8_serializer;
   localparam int IN_W      = 8;
   localparam int PIX_W     = 10;
   localparam int PPB       = 8;
   localparam int ROWS      = 4;
   localparam int COLS      = 16;
   localparam int TOTAL_PIX = ROWS * COLS;
   localparam int BURSTS    = TOTAL_PIX / PPB;
   localparam int COL_W     = $clog2(COLS);
   localparam int ROW_W     = $clog2(ROWS);
   localparam int TUP_W     = PIX_W + COL_W + ROW_W;
   localparam int RST_W     = 5 + TUP_W;

   typedef struct {
      logic [PPB*IN_W-1:0] data;
      logic                user;
   } burst_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   mono8_serializer_if #(
      .IN_PIXEL_BIT_WIDTH(IN_W), .PIXEL_BIT_WIDTH(PIX_W), .PIXELS_PER_BURST(PPB),
      .IN_ROWS(ROWS), .IN_COLS(COLS)
   ) bus ();

   mono8_serializer #(
      .IN_PIXEL_BIT_WIDTH(IN_W), .PIXEL_BIT_WIDTH(PIX_W), .PIXELS_PER_BURST(PPB),
      .IN_ROWS(ROWS), .IN_COLS(COLS)
   ) dut (
      .clk(clk),
      .s_axis_resetn(rstn),
      .bus(bus)
   );

   int     n_checks = 0;
   int     n_pass   = 0;
   burst_t tx_q[$];

   task automatic push_frame(input bit ramp, input int err_at);
      burst_t b;
      for (int i = 0; i < BURSTS; i++) begin
         for (int k = 0; k < PPB; k++)
            b.data[k*IN_W +: IN_W] = ramp ? IN_W'(i*PPB + k) : IN_W'($urandom);
         b.user = (i == 0) || (i == err_at);
         tx_q.push_back(b);
      end
   endtask

   task automatic push_junk(input int n);
      burst_t b;
      for (int i = 0; i < n; i++) begin
         b.data = {PPB{8'hAA}};
         b.user = 1'b0;
         tx_q.push_back(b);
      end
   endtask

   // Arm from IDLE; the first WAIT_SOF cycle must show busy, ready and a cleared error.
   task automatic arm(input string name);
      bus.ap_start = 1'b1;
      @(posedge clk); #1;
      bus.ap_start = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.ap_idle, bus.frame_err, bus.s_axis_tready} !== 3'b001)
         $display("FAIL %s arm: idle/err/s_tready got %b expected 001", name,
                  {bus.ap_idle, bus.frame_err, bus.s_axis_tready});
      else n_pass++;
      @(posedge clk); #1;
   endtask

   // Streams tx_q into the DUT and checks every output cycle against the queue model.
   // mode: 0 = m_tready always 1, 1 = alternating 1/0, 2 = random.
   task automatic run_frame(input string name, input int mode, input int gap_pct,
                            input int abort_after, input bit hold_start);
      logic [IN_W-1:0]  exp_q[$];
      logic [TUP_W-1:0] got, exp, prev_tuple;
      burst_t b;
      bit synced = 0, exp_err = 0, finished = 0, aborted = 0, prev_stall = 0, drop_valid = 0;
      int nb = 0, npix = 0, first_hs = -1, last_hs = -1;
      prev_tuple = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.ap_start = hold_start;
         if (drop_valid) begin
            bus.s_axis_tvalid = 1'b0;
            drop_valid = 0;
         end
         if (!bus.s_axis_tvalid && tx_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = tx_q[0].data;
            bus.s_axis_tuser  = tx_q[0].user;
         end
         case (mode)
            0:       bus.m_axis_tready = 1'b1;
            1:       bus.m_axis_tready = (cyc % 2 == 0);
            default: bus.m_axis_tready = 1'($urandom_range(1));
         endcase
         @(negedge clk);
         got = {bus.m_axis_tdata, bus.cnt_col, bus.cnt_row};

         n_checks++;
         if (bus.frame_err !== exp_err)
            $display("FAIL %s frame_err cyc %0d: got %b expected %b", name, cyc, bus.frame_err, exp_err);
         else n_pass++;

         if (prev_stall) begin
            n_checks++;
            if ({bus.m_axis_tvalid, got} !== {1'b1, prev_tuple})
               $display("FAIL %s stall_hold cyc %0d: got %h expected %h", name, cyc,
                        {bus.m_axis_tvalid, got}, {1'b1, prev_tuple});
            else n_pass++;
         end
         prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
         prev_tuple = got;

         if (bus.s_axis_tready && bus.m_axis_tvalid) begin
            n_checks++;
            if (!(bus.m_axis_tready && (int'(bus.cnt_col) % PPB == PPB - 1)))
               $display("FAIL %s s_tready cyc %0d: ready with m_tready=%b col=%0d", name, cyc,
                        bus.m_axis_tready, bus.cnt_col);
            else n_pass++;
         end

         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL %s pixel %0d: got %h expected no pixel", name, npix, got);
            end else begin
               exp = {PIX_W'(exp_q.pop_front()), COL_W'(npix % COLS), ROW_W'(npix / COLS)};
               if (got !== exp)
                  $display("FAIL %s pixel %0d: got %h expected %h", name, npix, got, exp);
               else n_pass++;
            end
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            npix++;
         end

         if (bus.s_axis_tvalid && bus.s_axis_tready) begin
            b = tx_q.pop_front();
            drop_valid = 1;
            if (synced) begin
               n_checks++;
               if (nb >= BURSTS)
                  $display("FAIL %s burst_count: accepted burst %0d expected at most %0d", name, nb + 1, BURSTS);
               else n_pass++;
               if (b.user) exp_err = 1;
            end
            if (synced || b.user) begin
               synced = 1;
               nb++;
               for (int k = 0; k < PPB; k++) exp_q.push_back(b.data[k*IN_W +: IN_W]);
            end
         end

         if (bus.ap_done) begin
            n_checks++;
            if (cyc != last_hs + 1 || npix != TOTAL_PIX || exp_q.size() != 0)
               $display("FAIL %s done: at cyc %0d after %0d pixels, expected cyc %0d after %0d",
                        name, cyc, npix, last_hs + 1, TOTAL_PIX);
            else n_pass++;
            if (mode == 0 && gap_pct == 0) begin
               n_checks++;
               if (last_hs - first_hs != TOTAL_PIX - 1)
                  $display("FAIL %s throughput: span %0d cycles expected %0d", name,
                           last_hs - first_hs, TOTAL_PIX - 1);
               else n_pass++;
            end
            finished = 1;
         end else if (abort_after > 0 && npix == abort_after) begin
            finished = 1;
            aborted  = 1;
         end
         if (finished) break;
         @(posedge clk); #1;
      end

      if (!finished) begin
         n_checks++;
         $display("FAIL %s timeout: got %0d pixels expected %0d", name, npix, TOTAL_PIX);
         bus.s_axis_tvalid = 1'b0;
         tx_q.delete();
      end else if (aborted) begin
         @(posedge clk); #1;
         tx_q.delete();
      end else begin
         @(posedge clk); #1;
         bus.ap_start      = 1'b0;
         bus.s_axis_tvalid = 1'b0;
         for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.ap_done, bus.ap_idle, bus.s_axis_tready, bus.m_axis_tvalid} !== 4'b0100)
               $display("FAIL %s post_done %0d: done/idle/s_rdy/m_vld got %b expected 0100", name, i,
                        {bus.ap_done, bus.ap_idle, bus.s_axis_tready, bus.m_axis_tvalid});
            else n_pass++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      n_checks++;
      if ({bus.ap_idle, bus.ap_done, bus.frame_err, bus.s_axis_tready, bus.m_axis_tvalid,
           bus.m_axis_tdata, bus.cnt_col, bus.cnt_row} !== {1'b1, {(RST_W-1){1'b0}}})
         $display("FAIL reset outputs: got %h expected %h",
                  {bus.ap_idle, bus.ap_done, bus.frame_err, bus.s_axis_tready, bus.m_axis_tvalid,
                   bus.m_axis_tdata, bus.cnt_col, bus.cnt_row}, {1'b1, {(RST_W-1){1'b0}}});
      else n_pass++;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   task automatic test_ramp();
      push_frame(1'b1, -1);
      arm("ramp");
      run_frame("ramp", 0, 0, 0, 1'b0);
   endtask

   task automatic test_stall();
      push_frame(1'b0, -1);
      arm("stall");
      run_frame("stall", 1, 0, 0, 1'b0);
   endtask

   task automatic test_drop_pre_sof();
      push_junk(2);
      push_frame(1'b1, -1);
      arm("pre_sof");
      run_frame("pre_sof", 0, 0, 0, 1'b0);
   endtask

   task automatic test_mid_sof();
      push_frame(1'b0, 2);
      arm("mid_sof");
      run_frame("mid_sof", 2, 10, 0, 1'b0);
      @(negedge clk);
      n_checks++;
      if (bus.frame_err !== 1'b1)
         $display("FAIL mid_sof sticky: frame_err got %b expected 1", bus.frame_err);
      else n_pass++;
      @(posedge clk); #1;
      push_frame(1'b0, -1);
      arm("mid_sof_clear");
      run_frame("mid_sof_clear", 0, 0, 0, 1'b0);
   endtask

   task automatic test_reset_mid();
      push_frame(1'b1, -1);
      arm("reset_mid");
      run_frame("reset_mid", 0, 0, 21, 1'b0);
      bus.s_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b0;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.ap_idle, bus.ap_done, bus.frame_err, bus.s_axis_tready, bus.m_axis_tvalid,
           bus.m_axis_tdata, bus.cnt_col, bus.cnt_row} !== {1'b1, {(RST_W-1){1'b0}}})
         $display("FAIL reset_mid outputs: got %h expected %h",
                  {bus.ap_idle, bus.ap_done, bus.frame_err, bus.s_axis_tready, bus.m_axis_tvalid,
                   bus.m_axis_tdata, bus.cnt_col, bus.cnt_row}, {1'b1, {(RST_W-1){1'b0}}});
      else n_pass++;
      @(posedge clk); #1;
      push_frame(1'b1, -1);
      arm("after_reset");
      run_frame("after_reset", 2, 20, 0, 1'b0);
   endtask

   task automatic test_start_ignored();
      push_frame(1'b0, -1);
      arm("start_ignored");
      run_frame("start_ignored", 1, 15, 0, 1'b1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         push_junk(int'($urandom_range(3)));
         push_frame(1'b0, ($urandom_range(1) == 1) ? int'($urandom_range(BURSTS - 1, 1)) : -1);
         arm("random");
         run_frame("random", 2, int'($urandom_range(40)), 0, 1'($urandom_range(1)));
      end
   endtask

   initial begin
      bus.ap_start      = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tuser  = 1'b0;
      bus.m_axis_tready = 1'b0;
      test_reset();
      test_ramp();
      test_stall();
      test_drop_pre_sof();
      test_mid_sof();
      test_reset_mid();
      test_start_ignored();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
